// File: rtl/virtual_ds2431_rom.sv
// virtual_ds2431_rom: ROM-function controller for the virtual DS2431.
// Sits behind the 1-Wire byte I/O stage, decodes the ROM command set
// (Read, Match, Skip, Resume, Overdrive-Skip, Overdrive-Match) and hands
// the I/O stage to the memory-function layer on a successful ROM phase.
// Optional feature macro: VDS2431_OD_CMD_EN enables the overdrive commands
// (0x3C, 0x69) and the overdrive bus reset input. Without it, odMode is 0.
module virtual_ds2431_rom #(
  parameter logic [63:0] ROM_ID = 64'hB400_000A_1B2C_3D2D
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       nBusRst,
  input  logic       nODBusRst,
  input  logic       done,
  input  logic [7:0] receiveDat,
  output logic       trig,
  output logic       nRxTx,
  output logic [7:0] sentDat,
  output logic       odMode,
  output logic       funcGrant,
  output logic       funcStart,
  input  logic       fnTrig,
  input  logic       fnNRxTx,
  input  logic [7:0] fnSentDat,
  output logic       fnDone
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_CMD   = 3'd2,
    S_TXROM = 3'd3,
    S_RXROM = 3'd4,
    S_FUNC  = 3'd5
  } state_t;

  state_t      r_state;
  logic        r_nbus_d;
  logic        r_done_d;
  logic        r_evt;
  logic [7:0]  r_rx;
  logic [2:0]  r_idx;
  logic [1:0]  r_rst_cnt;
  logic        r_rc;
  logic        r_od;
  logic        r_is69;
  logic        r_trig;
  logic        r_tcnt;
  logic        r_issue;
  logic        r_nrxtx;
  logic [7:0]  r_sent;
  logic        r_grant;
  logic        r_fstart;

  logic        w_std_fall;
  logic        w_od_fall;
  logic        w_bus_evt;
  logic        w_done_rise;
  logic        w_xfer_state;

  // ROM code byte i, LSB byte first
  function automatic logic [7:0] rom_byte(input logic [2:0] idx);
    rom_byte = ROM_ID[{idx, 3'b000} +: 8];
  endfunction

`ifdef VDS2431_OD_CMD_EN
  logic r_nod_d;

  // Previous level of the overdrive bus reset for falling-edge detection
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) r_nod_d <= 1'b1;
    else       r_nod_d <= nODBusRst;
  end

  assign w_od_fall = r_nod_d & ~nODBusRst;
`else
  logic w_unused_od;
  assign w_unused_od = nODBusRst;
  assign w_od_fall   = 1'b0;
`endif

  // Previous levels of standard bus reset and done for edge detection
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_nbus_d <= 1'b1;
      r_done_d <= 1'b0;
    end else begin
      r_nbus_d <= nBusRst;
      r_done_d <= done;
    end
  end

  assign w_std_fall   = r_nbus_d & ~nBusRst;
  assign w_bus_evt    = w_std_fall | w_od_fall;
  assign w_done_rise  = done & ~r_done_d;
  assign w_xfer_state = (r_state == S_CMD) || (r_state == S_TXROM) ||
                        (r_state == S_RXROM);

  // ROM-phase controller: bus reset handling, byte handshake, command decode
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state   <= S_IDLE;
      r_evt     <= 1'b0;
      r_rx      <= 8'h00;
      r_idx     <= 3'd0;
      r_rst_cnt <= 2'd0;
      r_rc      <= 1'b0;
      r_od      <= 1'b0;
      r_is69    <= 1'b0;
      r_trig    <= 1'b0;
      r_tcnt    <= 1'b0;
      r_issue   <= 1'b0;
      r_nrxtx   <= 1'b0;
      r_sent    <= 8'h00;
      r_grant   <= 1'b0;
      r_fstart  <= 1'b0;
    end else begin
      r_fstart <= 1'b0;
      if (w_bus_evt) begin
        // A bus reset abandons whatever was in flight, including a done edge
        r_state   <= S_RST;
        r_grant   <= 1'b0;
        r_idx     <= 3'd0;
        r_rst_cnt <= 2'd0;
        r_trig    <= 1'b0;
        r_tcnt    <= 1'b0;
        r_issue   <= 1'b0;
        r_evt     <= 1'b0;
        r_nrxtx   <= 1'b0;
        r_sent    <= 8'h00;
        if (w_std_fall) r_od <= 1'b0;
      end else begin
        // trig is raised one cycle after a request and held for two cycles
        if (r_issue) begin
          r_trig  <= 1'b1;
          r_tcnt  <= 1'b1;
          r_issue <= 1'b0;
        end else if (r_trig) begin
          if (r_tcnt) r_tcnt <= 1'b0;
          else        r_trig <= 1'b0;
        end

        // A completed byte is captured here and acted on the next cycle
        r_evt <= w_done_rise && w_xfer_state;
        if (w_done_rise) r_rx <= receiveDat;

        case (r_state)
          S_RST: begin
            if (w_done_rise || ((r_rst_cnt == 2'd2) && done)) begin
              r_state <= S_CMD;
              r_nrxtx <= 1'b0;
              r_sent  <= 8'h00;
              r_issue <= 1'b1;
            end else if (r_rst_cnt != 2'd2) begin
              r_rst_cnt <= r_rst_cnt + 2'd1;
            end
          end

          S_CMD: begin
            if (r_evt) begin
              r_is69 <= 1'b0;
              r_idx  <= 3'd0;
              case (r_rx)
                8'h33: begin
                  r_rc    <= 1'b1;
                  r_state <= S_TXROM;
                  r_nrxtx <= 1'b1;
                  r_sent  <= rom_byte(3'd0);
                  r_issue <= 1'b1;
                end
                8'hCC: begin
                  r_rc     <= 1'b0;
                  r_state  <= S_FUNC;
                  r_grant  <= 1'b1;
                  r_fstart <= 1'b1;
                end
                8'h55: begin
                  r_state <= S_RXROM;
                  r_nrxtx <= 1'b0;
                  r_issue <= 1'b1;
                end
                8'hA5: begin
                  if (r_rc) begin
                    r_state  <= S_FUNC;
                    r_grant  <= 1'b1;
                    r_fstart <= 1'b1;
                  end else begin
                    r_state <= S_IDLE;
                  end
                end
`ifdef VDS2431_OD_CMD_EN
                8'h3C: begin
                  r_od     <= 1'b1;
                  r_rc     <= 1'b0;
                  r_state  <= S_FUNC;
                  r_grant  <= 1'b1;
                  r_fstart <= 1'b1;
                end
                8'h69: begin
                  r_od    <= 1'b1;
                  r_is69  <= 1'b1;
                  r_state <= S_RXROM;
                  r_nrxtx <= 1'b0;
                  r_issue <= 1'b1;
                end
`endif
                default: begin
                  r_state <= S_IDLE;
                end
              endcase
            end
          end

          S_TXROM: begin
            if (r_evt) begin
              if (r_idx == 3'd7) begin
                r_idx    <= 3'd0;
                r_state  <= S_FUNC;
                r_grant  <= 1'b1;
                r_fstart <= 1'b1;
                r_nrxtx  <= 1'b0;
                r_sent   <= 8'h00;
              end else begin
                r_idx   <= r_idx + 3'd1;
                r_sent  <= rom_byte(r_idx + 3'd1);
                r_issue <= 1'b1;
              end
            end
          end

          S_RXROM: begin
            if (r_evt) begin
              if (r_rx != rom_byte(r_idx)) begin
                // Not addressed: drop off the bus until the next reset
                r_idx   <= 3'd0;
                r_state <= S_IDLE;
                r_rc    <= 1'b0;
                if (r_is69) r_od <= 1'b0;
              end else if (r_idx == 3'd7) begin
                r_idx    <= 3'd0;
                r_rc     <= 1'b1;
                r_state  <= S_FUNC;
                r_grant  <= 1'b1;
                r_fstart <= 1'b1;
              end else begin
                r_idx   <= r_idx + 3'd1;
                r_issue <= 1'b1;
              end
            end
          end

          S_FUNC: begin
            r_grant <= 1'b1;
          end

          S_IDLE: begin
            r_nrxtx <= 1'b0;
            r_sent  <= 8'h00;
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // The function layer owns the handshake while granted; a bus reset edge
  // kills our own trig in the same cycle it is seen.
  assign trig      = r_grant ? fnTrig    : (r_trig & ~w_bus_evt);
  assign nRxTx     = r_grant ? fnNRxTx   : r_nrxtx;
  assign sentDat   = r_grant ? fnSentDat : r_sent;
  assign fnDone    = r_grant & done;
  assign funcGrant = r_grant;
  assign funcStart = r_fstart;
  assign odMode    = r_od;

endmodule

// File: tb/tb_virtual_ds2431_rom.sv
// Self-checking bench for virtual_ds2431_rom: emulates the 1-Wire byte I/O
// stage and compares against a transaction-level model of the ROM commands.
`timescale 1ns/1ps
module tb_virtual_ds2431_rom;
  localparam logic [63:0] TB_ROM = 64'hB400_000A_1B2C_3D2D;
`ifdef VDS2431_OD_CMD_EN
  localparam bit OD_EN = 1'b1;
`else
  localparam bit OD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       nRst, nBusRst, nODBusRst, done;
  logic [7:0] receiveDat;
  logic       trig, nRxTx, odMode, funcGrant, funcStart, fnDone;
  logic [7:0] sentDat;
  logic       fnTrig, fnNRxTx;
  logic [7:0] fnSentDat;

  always #10 clk = ~clk;

  virtual_ds2431_rom #(.ROM_ID(TB_ROM)) dut (
    .clk(clk), .nRst(nRst), .nBusRst(nBusRst), .nODBusRst(nODBusRst),
    .done(done), .receiveDat(receiveDat), .trig(trig), .nRxTx(nRxTx),
    .sentDat(sentDat), .odMode(odMode), .funcGrant(funcGrant),
    .funcStart(funcStart), .fnTrig(fnTrig), .fnNRxTx(fnNRxTx),
    .fnSentDat(fnSentDat), .fnDone(fnDone)
  );

  int total = 0;
  int bad   = 0;
  int trig_rises = 0;
  int fs_cnt = 0;
  logic trig_q = 1'b0;

  // reference model state
  bit m_rc = 1'b0;
  bit m_od = 1'b0;

  always @(negedge clk) begin
    if (trig && !trig_q) trig_rises++;
    trig_q = trig;
    if (funcStart) fs_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] rom_b(input int i);
    logic [63:0] r;
    r = TB_ROM;
    return r[i*8 +: 8];
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_trig(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (trig) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check_val("trig_timeout", 0, 1);
  endtask

  // One byte transfer as the I/O stage sees it: wait for trig, report the
  // direction/data the controller set up, then complete with byte rx.
  task automatic xfer(input logic [7:0] rx, output logic dir, output logic [7:0] sd,
                      output bit ok);
    int w;
    dir = 1'b0;
    sd  = 8'h00;
    wait_trig(ok);
    if (!ok) return;
    dir  = nRxTx;
    sd   = sentDat;
    done = 1'b0;
    w = 1;
    tick();
    while (trig && w < 8) begin
      w++;
      tick();
    end
    check_val("trig_width", w, 2);
    repeat ($urandom_range(1, 6)) tick();
    receiveDat = rx;
    done = 1'b1;
    tick();
    check_val("no_early_trig", trig, 0);
  endtask

  task automatic end_checks(input bit grant);
    int snap;
    snap = trig_rises;
    repeat (12) tick();
    check_val("no_extra_trig", trig_rises - snap, 0);
    check_val("grant", funcGrant, grant);
    check_val("odmode", odMode, m_od);
    check_val("fstart_cnt", fs_cnt, grant);
    check_val("fndone", fnDone, grant);
    if (grant) begin
      logic       nr;
      logic [7:0] sd;
      nr = 1'($urandom_range(0, 1));
      sd = 8'($urandom_range(0, 255));
      #1;
      fnNRxTx = nr;
      fnSentDat = sd;
      fnTrig = 1'b1;
      #1;
      check_val("mux_trig", trig, 1);
      check_val("mux_dir", nRxTx, nr);
      check_val("mux_data", sentDat, sd);
      fnTrig = 1'b0;
    end
  endtask

  task automatic bus_reset(input bit od, input bit keep_done);
    fs_cnt = 0;
    fnTrig = 1'b0;
    if (od) nODBusRst = 1'b0;
    else    nBusRst = 1'b0;
    if (!keep_done) done = 1'b0;
    repeat (keep_done ? 1 : $urandom_range(2, 5)) tick();
    nBusRst = 1'b1;
    nODBusRst = 1'b1;
    if (!keep_done) begin
      repeat ($urandom_range(1, 5)) tick();
      done = 1'b1;
      tick();
      check_val("pres_early", trig, 0);
    end
  endtask

  task automatic session(input bit od, input bit keep_done, input logic [7:0] cmd,
                         input int bad_idx);
    bit         grant, is69, od_dec, ok;
    int         kind, nrx;
    logic       dir;
    logic [7:0] sd, rxb;
    // model: what the ROM layer must do for this command
    if (!od) m_od = 1'b0;
    grant = 1'b0; kind = 0; nrx = 0; is69 = 1'b0;
    if (cmd == 8'h33) begin
      m_rc = 1'b1; kind = 1; grant = 1'b1;
    end else if (cmd == 8'hCC) begin
      m_rc = 1'b0; grant = 1'b1;
    end else if (cmd == 8'h55) begin
      kind = 2;
    end else if (cmd == 8'hA5) begin
      grant = m_rc;
    end else if (cmd == 8'h3C && OD_EN) begin
      m_od = 1'b1; m_rc = 1'b0; grant = 1'b1;
    end else if (cmd == 8'h69 && OD_EN) begin
      m_od = 1'b1; kind = 2; is69 = 1'b1;
    end
    od_dec = m_od;
    if (kind == 2) begin
      if (bad_idx >= 0 && bad_idx < 8) begin
        nrx = bad_idx + 1; m_rc = 1'b0;
        if (is69) m_od = 1'b0;
      end else begin
        nrx = 8; m_rc = 1'b1; grant = 1'b1;
      end
    end

    bus_reset(od, keep_done);
    xfer(cmd, dir, sd, ok);
    if (!ok) return;
    check_val("cmd_dir", dir, 0);
    if (kind == 1) begin
      for (int i = 0; i < 8; i++) begin
        xfer(8'($urandom_range(0, 255)), dir, sd, ok);
        if (!ok) return;
        if (i == 0) check_val("od_at_trig", odMode, od_dec);
        check_val("tx_dir", dir, 1);
        check_val("tx_byte", sd, rom_b(i));
      end
    end else if (kind == 2) begin
      for (int i = 0; i < nrx; i++) begin
        rxb = rom_b(i);
        if (i == bad_idx) rxb = rxb ^ 8'($urandom_range(1, 255));
        xfer(rxb, dir, sd, ok);
        if (!ok) return;
        if (i == 0) check_val("od_at_trig", odMode, od_dec);
        check_val("rx_dir", dir, 0);
      end
    end
    end_checks(grant);
  endtask

  // Bus reset while Match ROM is receiving byte 5
  task automatic abort_test();
    logic       dir;
    logic [7:0] sd;
    bit         ok;
    int         snap;
    bus_reset(1'b0, 1'b0);
    m_od = 1'b0;
    xfer(8'h55, dir, sd, ok);
    if (!ok) return;
    for (int i = 0; i < 5; i++) begin
      xfer(rom_b(i), dir, sd, ok);
      if (!ok) return;
    end
    wait_trig(ok);
    if (!ok) return;
    fs_cnt = 0;
    nBusRst = 1'b0;
    done = 1'b0;
    #1;
    check_val("abort_trig_low", trig, 0);
    snap = trig_rises;
    tick();
    check_val("abort_grant", funcGrant, 0);
    repeat (3) tick();
    nBusRst = 1'b1;
    tick();
    check_val("abort_no_trig", trig_rises - snap, 0);
    done = 1'b1;
    tick();
    xfer(8'hCC, dir, sd, ok);
    if (!ok) return;
    check_val("abort_pres_dir", dir, 0);
    m_rc = 1'b0;
    end_checks(1'b1);
  endtask

  initial begin
    logic [7:0] cmd;
    logic [7:0] cmds [6];
    bit         od, kd;
    int         bi;
    cmds = '{8'h33, 8'hCC, 8'h55, 8'hA5, 8'h3C, 8'h69};
    nRst = 1'b0; nBusRst = 1'b1; nODBusRst = 1'b1; done = 1'b1;
    receiveDat = 8'h00; fnTrig = 1'b0; fnNRxTx = 1'b0; fnSentDat = 8'h00;
    repeat (3) tick();
    check_val("rst_trig", trig, 0);
    check_val("rst_nrxtx", nRxTx, 0);
    check_val("rst_sentdat", sentDat, 0);
    check_val("rst_odmode", odMode, 0);
    check_val("rst_grant", funcGrant, 0);
    check_val("rst_fstart", funcStart, 0);
    check_val("rst_fndone", fnDone, 0);
    nRst = 1'b1;
    tick();

    session(1'b0, 1'b0, 8'h33, -1);
    session(1'b0, 1'b0, 8'h55, -1);
    session(1'b0, 1'b0, 8'hA5, -1);
    session(1'b0, 1'b0, 8'h55, 3);
    session(1'b0, 1'b0, 8'hA5, -1);
`ifdef VDS2431_OD_CMD_EN
    session(1'b0, 1'b0, 8'h3C, -1);
    session(1'b1, 1'b0, 8'hCC, -1);
    session(1'b0, 1'b0, 8'hCC, -1);
    session(1'b0, 1'b0, 8'h69, 2);
    session(1'b0, 1'b1, 8'h69, -1);
`else
    session(1'b0, 1'b0, 8'h69, -1);
    session(1'b0, 1'b0, 8'hCC, -1);
    nODBusRst = 1'b0;
    repeat (3) tick();
    nODBusRst = 1'b1;
    tick();
    check_val("od_rst_ignored", funcGrant, 1);
    check_val("od_const0", odMode, 0);
`endif
    abort_test();
    session(1'b0, 1'b1, 8'h33, -1);

    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 3) != 0) cmd = cmds[$urandom_range(0, 5)];
      else                           cmd = 8'($urandom_range(0, 255));
      od = OD_EN && ($urandom_range(0, 1) == 1);
      kd = ($urandom_range(0, 3) == 0);
      bi = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
      session(od, kd, cmd, bi);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
